// File: rtl/voq_multi_fifo.sv
// Multi-queue command FIFO: NQ virtual output queues partitioned in one RAM,
// one push and one pop per cycle, registered read data, sticky error flags.

module voq_q_ctrl #(
  parameter int DEPTH        = 64,
  parameter int AFULL_THRESH = 60
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     i_push,
  input  logic                     i_pop,
  output logic [$clog2(DEPTH)-1:0] o_wptr,
  output logic [$clog2(DEPTH)-1:0] o_rptr,
  output logic                     o_empty,
  output logic                     o_full,
  output logic                     o_afull
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_cnt;

  // Pointers wrap modulo DEPTH by width; count spans 0..DEPTH.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + AW'(1);
      if (i_pop)  r_rptr <= r_rptr + AW'(1);
      case ({i_push, i_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign o_wptr  = r_wptr;
  assign o_rptr  = r_rptr;
  assign o_empty = (r_cnt == '0);
  assign o_full  = (r_cnt == CW'(DEPTH));
  assign o_afull = (r_cnt >= CW'(AFULL_THRESH));
endmodule

module voq_multi_fifo #(
  parameter int WIDTH        = 72,
  parameter int DEPTH        = 64,
  parameter int NQ           = 4,
  parameter int AFULL_THRESH = DEPTH - 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  we,
  input  logic [$clog2(NQ)-1:0] wqid,
  input  logic [WIDTH-1:0]      din,
  input  logic                  re,
  input  logic [$clog2(NQ)-1:0] rqid,
  output logic [WIDTH-1:0]      dout,
  output logic                  dout_valid,
  output logic [NQ-1:0]         empty,
  output logic [NQ-1:0]         full,
  output logic [NQ-1:0]         afull,
  output logic                  ovf_err,
  output logic                  udf_err,
  input  logic                  clr_err
);
  localparam int AW = $clog2(DEPTH);

  logic [NQ-1:0]         w_push, w_pop;
  logic [NQ-1:0][AW-1:0] w_wptr, w_rptr;
  logic                  w_push_ok, w_pop_ok;
  logic                  w_ovf_ev, w_udf_ev;

  logic [WIDTH-1:0]      r_mem [NQ*DEPTH];
  logic [WIDTH-1:0]      r_dout;
  logic                  r_dv, r_ovf, r_udf;

  // Accept decisions use pre-edge flags only: no full-queue push on a
  // same-cycle pop, no empty-queue bypass from push to pop.
  assign w_push_ok = we & ~full[wqid];
  assign w_pop_ok  = re & ~empty[rqid];
  assign w_ovf_ev  = we & full[wqid];
  assign w_udf_ev  = re & empty[rqid];
  assign w_push    = w_push_ok ? (NQ'(1) << wqid) : '0;
  assign w_pop     = w_pop_ok  ? (NQ'(1) << rqid) : '0;

  genvar q;
  generate
    for (q = 0; q < NQ; q++) begin : g_q
      voq_q_ctrl #(
        .DEPTH        (DEPTH),
        .AFULL_THRESH (AFULL_THRESH)
      ) u_q (
        .clk     (clk),
        .rstn    (rstn),
        .i_push  (w_push[q]),
        .i_pop   (w_pop[q]),
        .o_wptr  (w_wptr[q]),
        .o_rptr  (w_rptr[q]),
        .o_empty (empty[q]),
        .o_full  (full[q]),
        .o_afull (afull[q])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[{wqid, w_wptr[wqid]}] <= din;
  end

  // New error events win over a same-cycle clear.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_dout <= '0;
      r_dv   <= 1'b0;
      r_ovf  <= 1'b0;
      r_udf  <= 1'b0;
    end else begin
      r_dv <= w_pop_ok;
      if (w_pop_ok) r_dout <= r_mem[{rqid, w_rptr[rqid]}];
      r_ovf <= (r_ovf & ~clr_err) | w_ovf_ev;
      r_udf <= (r_udf & ~clr_err) | w_udf_ev;
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dv;
  assign ovf_err    = r_ovf;
  assign udf_err    = r_udf;
endmodule

// File: tb/tb_voq_multi_fifo.sv
// Directed + randomised bench for voq_multi_fifo against a per-queue model.

module tb_voq_multi_fifo;
  localparam int W  = 16;
  localparam int D  = 8;
  localparam int N  = 4;
  localparam int AF = 6;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          we = 1'b0, re = 1'b0, clr_err = 1'b0;
  logic [1:0]    wqid = '0, rqid = '0;
  logic [W-1:0]  din = '0;
  logic [W-1:0]  dout;
  logic          dout_valid, ovf_err, udf_err;
  logic [N-1:0]  empty, full, afull;

  int n_chk = 0;
  int n_err = 0;

  // reference model
  logic [W-1:0] mm [N][D];
  int           hd [N];
  int           tl [N];
  int           cnt[N];
  logic [W-1:0] e_dout;
  logic         e_ovf, e_udf;

  voq_multi_fifo #(.WIDTH(W), .DEPTH(D), .NQ(N), .AFULL_THRESH(AF)) dut (
    .clk(clk), .rstn(rstn), .we(we), .wqid(wqid), .din(din),
    .re(re), .rqid(rqid), .dout(dout), .dout_valid(dout_valid),
    .empty(empty), .full(full), .afull(afull),
    .ovf_err(ovf_err), .udf_err(udf_err), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic mdl_reset();
    for (int q = 0; q < N; q++) begin
      hd[q] = 0; tl[q] = 0; cnt[q] = 0;
    end
    e_dout = '0; e_ovf = 1'b0; e_udf = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_empty"}, empty, 4'hF);
    chk({tag, "_full"},  full,  4'h0);
    chk({tag, "_afull"}, afull, 4'h0);
    chk({tag, "_dout"},  dout,  16'h0);
    chk({tag, "_dv"},    dout_valid, 1'b0);
    chk({tag, "_ovf"},   ovf_err, 1'b0);
    chk({tag, "_udf"},   udf_err, 1'b0);
  endtask

  // One clock with optional push/pop/clear; checks all outputs vs model.
  task automatic op(input bit w, input int wq, input logic [W-1:0] d,
                    input bit r, input int rq, input bit clr);
    bit wok, rok;
    logic [N-1:0] xe, xf, xa;
    we = w; wqid = 2'(wq); din = d; re = r; rqid = 2'(rq); clr_err = clr;
    wok = w && cnt[wq] != D;
    rok = r && cnt[rq] != 0;
    e_ovf = (e_ovf & ~clr) | (w & ~wok);
    e_udf = (e_udf & ~clr) | (r & ~rok);
    if (rok) begin
      e_dout = mm[rq][hd[rq]];
      hd[rq] = (hd[rq] + 1) % D;
      cnt[rq]--;
    end
    if (wok) begin
      mm[wq][tl[wq]] = d;
      tl[wq] = (tl[wq] + 1) % D;
      cnt[wq]++;
    end
    @(posedge clk); #1;
    we = 1'b0; re = 1'b0; clr_err = 1'b0;
    for (int q = 0; q < N; q++) begin
      xe[q] = cnt[q] == 0; xf[q] = cnt[q] == D; xa[q] = cnt[q] >= AF;
    end
    chk("dv",    dout_valid, rok);
    chk("dout",  dout, e_dout);
    chk("empty", empty, xe);
    chk("full",  full, xf);
    chk("afull", afull, xa);
    chk("ovf",   ovf_err, e_ovf);
    chk("udf",   udf_err, e_udf);
  endtask

  initial begin
    mdl_reset();
    #12;
    chk_idle("rst");
    rstn = 1'b1;
    @(posedge clk); #1;
    op(0, 0, 0, 0, 0, 0);
    chk_idle("idle");

    // q2 ordering
    op(1, 2, 16'h11, 0, 0, 0);
    op(1, 2, 16'h22, 0, 0, 0);
    op(1, 2, 16'h33, 0, 0, 0);
    op(0, 0, 0, 1, 2, 0); chk("q2_p0", dout, 16'h11);
    op(0, 0, 0, 1, 2, 0); chk("q2_p1", dout, 16'h22);
    op(0, 0, 0, 1, 2, 0); chk("q2_p2", dout, 16'h33);
    chk("q2_empty", empty, 4'hF);

    // q0 fill/drain, two passes to exercise wrap
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < D; i++) begin
        op(1, 0, W'(i + pass * 16), 0, 0, 0);
        chk("q0_afull", afull[0], (i + 1) >= AF);
        chk("q0_full",  full[0],  (i + 1) == D);
      end
      op(1, 0, 16'hDEAD, 0, 0, 0);
      chk("q0_ovf", ovf_err, 1'b1);
      chk("q0_full_hold", full[0], 1'b1);
      for (int i = 0; i < D; i++) begin
        op(0, 0, 0, 1, 0, 0);
        chk("q0_drain", dout, W'(i + pass * 16));
      end
      op(0, 0, 0, 0, 0, 1);
      chk("q0_clr", ovf_err, 1'b0);
    end

    // underflow and clear priority
    op(0, 0, 0, 1, 1, 0);
    chk("udf_set", udf_err, 1'b1);
    chk("udf_dv", dout_valid, 1'b0);
    chk("udf_hold", dout, 16'h17);
    op(0, 0, 0, 0, 0, 1);
    chk("udf_clr", udf_err, 1'b0);
    op(0, 0, 0, 1, 1, 1);
    chk("udf_win", udf_err, 1'b1);
    op(0, 0, 0, 0, 0, 1);

    // same-queue push/pop on q3
    op(1, 3, 16'hA0, 0, 0, 0);
    op(1, 3, 16'hA1, 1, 3, 0);
    chk("sq_one_dout", dout, 16'hA0);
    chk("sq_one_cnt", empty[3], 1'b0);
    op(0, 0, 0, 1, 3, 0);
    chk("sq_one_next", dout, 16'hA1);
    op(1, 3, 16'hB0, 1, 3, 0);
    chk("sq_emp_udf", udf_err, 1'b1);
    chk("sq_emp_dv", dout_valid, 1'b0);
    op(0, 0, 0, 1, 3, 1);
    chk("sq_emp_word", dout, 16'hB0);
    for (int i = 0; i < D; i++) op(1, 3, W'(16'h300 + i), 0, 0, 0);
    op(1, 3, 16'hFFF, 1, 3, 0);
    chk("sq_full_ovf", ovf_err, 1'b1);
    chk("sq_full_dout", dout, 16'h300);
    chk("sq_full_flag", full[3], 1'b0);
    for (int i = 1; i < D; i++) op(0, 0, 0, 1, 3, 0);
    chk("sq_full_last", dout, 16'h307);
    chk("sq_full_empty", empty[3], 1'b1);

    // randomised traffic
    for (int i = 0; i < 400; i++)
      op(bit'($urandom_range(0, 1)), $urandom_range(0, N - 1), W'($urandom),
         bit'($urandom_range(0, 1)), $urandom_range(0, N - 1), $urandom_range(0, 7) == 0);

    // reset mid-traffic, no clock needed
    op(1, 1, 16'h55, 0, 0, 0);
    op(1, 2, 16'h66, 1, 1, 0);
    op(1, 0, 16'h77, 1, 3, 0);
    rstn = 1'b0;
    #2;
    chk_idle("mrst");
    mdl_reset();
    #4;
    rstn = 1'b1;
    op(0, 0, 0, 0, 0, 0);
    chk_idle("post");
    op(1, 1, 16'h99, 0, 0, 0);
    op(0, 0, 0, 1, 1, 0);
    chk("post_pop", dout, 16'h99);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/voq_multi_fifo.md
# voq_multi_fifo

Multi-queue command FIFO for the VOQ packet path: NQ independent virtual output queues in one shared, partitioned RAM, single clock domain. Write side selects a queue per push, read side selects a queue per pop. Per-queue status, registered read data, and sticky overflow/underflow error flags. Replaces per-destination single-queue command FIFOs where one clock serves both producer and scheduler.

## Interface
- WIDTH, 72: command word width in bits, 1..128
- DEPTH, 64: entries per queue; power of two, 4..512
- NQ, 4: number of queues; power of two, 2..16
- AFULL_THRESH, DEPTH-4: afull[q] asserts when count[q] >= AFULL_THRESH; 1..DEPTH
- clk  in  1  sole clock, rising edge
- rstn  in  1  asynchronous, active-low reset
- we  in  1  push request
- wqid  in  log2(NQ)  push target queue
- din  in  WIDTH  push data
- re  in  1  pop request
- rqid  in  log2(NQ)  pop source queue
- dout  out  WIDTH  popped word, registered
- dout_valid  out  1  one-cycle pulse, dout holds a newly popped word
- empty  out  NQ  per-queue empty
- full  out  NQ  per-queue full
- afull  out  NQ  per-queue almost-full
- ovf_err  out  1  sticky: push to full queue
- udf_err  out  1  sticky: pop from empty queue
- clr_err  in  1  clears both sticky flags

## Operation
- Storage: NQ*DEPTH words; address = {qid, ptr}. Queue regions are fixed, no sharing.
- Per queue: wptr, rptr (log2(DEPTH) bits, wrap modulo DEPTH naturally), count (log2(DEPTH)+1 bits, 0..DEPTH).
- Push accepted iff we && !full[wqid]: mem[{wqid,wptr}] <= din, wptr+1, count+1.
- Push with full[wqid]: dropped, no state change except ovf_err <= 1.
- Pop accepted iff re && !empty[rqid]: dout <= mem[{rqid,rptr}], dout_valid <= 1, rptr+1, count-1.
- Pop with empty[rqid]: dout holds, dout_valid <= 0, udf_err <= 1.
- Simultaneous push/pop, different queues: both independent.
- Simultaneous push/pop, same queue: decisions use pre-edge flags. Both accepted -> count unchanged, both pointers advance. Full queue: push rejected (ovf_err) even though pop frees a slot. Empty queue: pop rejected (udf_err); no write-to-read bypass; pushed word is stored.
- Flags: empty[q] = (count==0), full[q] = (count==DEPTH), afull[q] = (count>=AFULL_THRESH), all driven from registered counts.
- clr_err clears both flags; a new error event in the same cycle wins (flag set).
- dout holds its last value whenever dout_valid=0.

## Timing
- Reset (rstn=0, immediate, no clock needed): all pointers/counts 0; empty = all ones; full = 0; afull = 0; dout = 0; dout_valid = 0; ovf_err = udf_err = 0. RAM contents are not reset and are unobservable until rewritten.
- Reset mid-operation drops all queued data; first cycle after release behaves as post-reset idle.
- Push at edge N: empty/afull/full of that queue update at edge N; pop of that word legal in cycle N+1; data on dout with dout_valid=1 after edge N+1 (one-cycle pop latency).
- Back-to-back pops of a queue: one word per cycle, in push order.
- Throughput: one push and one pop per cycle sustained.
- Error flags set at the edge of the offending request.

## Test plan
- Reset then idle: empty=all ones, full=0, afull=0, dout=0, dout_valid=0, errors 0; assert rstn low mid-traffic -> same values immediately, no clock.
- Push 0x11,0x22,0x33 to q2 then pop q2 x3 -> dout 0x11,0x22,0x33 on consecutive cycles, dout_valid high 3 cycles, empty[2]=1 after third pop; other queues untouched.
- Fill q0 with DEPTH words (value=index): afull[0] rises on push AFULL_THRESH, full[0] on push DEPTH; extra push -> ovf_err=1, count stays DEPTH; drain -> values 0..DEPTH-1 in order, pointers wrap, refill/drain second pass matches.
- Pop empty q1 -> udf_err=1, dout_valid=0, dout unchanged; clr_err -> 0; clr_err with simultaneous empty pop -> udf_err stays 1.
- Same-cycle push/pop: q3 holding 1 word -> both accepted, count stays 1, order preserved; q3 empty -> pop rejected, udf_err=1, pushed word later pops correctly; q3 full -> push rejected, ovf_err=1, pop returns oldest.
- Randomised interleaved push/pop across all NQ queues vs. per-queue reference model: every dout matches model, flags match count each cycle.
